// File: rtl/uart_pkg.sv
// Shared types and helpers for the multi-requester UART transmit scheduler.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } tx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Number of baud ticks a complete frame occupies on the line.
    function automatic int frame_ticks(input int parity, input int stop_bits);
        return 1 + 8 + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
    endfunction

    function automatic logic parity_bit(input logic [7:0] b, input int parity);
        return (parity == PAR_ODD) ? ~(^b) : (^b);
    endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Requester handshake plus baud-generator and serial-line signals of the scheduler.
interface uart_tx_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] data;
    logic [NUM_REQ-1:0]   gnt;
    logic                 baud_en;
    logic                 baud_tick;
    logic                 txd;
    logic                 busy;
    logic [ID_W-1:0]      cur_id;

    modport master (
        output req, data, baud_tick,
        input  gnt, baud_en, txd, busy, cur_id
    );

    modport slave (
        input  req, data, baud_tick,
        output gnt, baud_en, txd, busy, cur_id
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr, wrapping.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        s = (s >= N) ? s - N : s;
        return IDX_W'(s);
    endfunction

    // Scan from the farthest offset down so the closest asserted request wins.
    always_comb begin
        idx   = {IDX_W{1'b0}};
        valid = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[wrap_idx(ptr, k)]) begin
                idx   = wrap_idx(ptr, k);
                valid = 1'b1;
            end else begin
                valid = valid;
            end
        end
        gnt = valid ? ({{(N-1){1'b0}}, 1'b1} << idx) : {N{1'b0}};
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin shared UART transmitter: arbitrates byte requesters and frames each byte.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int ID_W      = 2
) (
    input logic            clk,
    input logic            rst,
    uart_tx_sched_if.slave bus
);

    localparam int FRAME_TICKS = frame_ticks(PARITY, STOP_BITS);
    localparam logic [3:0] LAST_TICK = 4'(FRAME_TICKS - 1);

    tx_state_t            state_r, state_s;
    logic [ID_W-1:0]      ptr_r, ptr_s;
    logic [7:0]           shift_r, shift_s;
    logic                 par_r, par_s;
    logic [3:0]           tick_cnt_r, tick_cnt_s;
    logic [NUM_REQ-1:0]   gnt_r, gnt_s;
    logic                 baud_en_r, baud_en_s;
    logic                 txd_r, txd_s;
    logic                 busy_r, busy_s;
    logic [ID_W-1:0]      cur_id_r, cur_id_s;

    logic [NUM_REQ-1:0]   arb_gnt_s;
    logic [ID_W-1:0]      arb_idx_s;
    logic                 arb_valid_s;
    logic [7:0]           sel_byte_s;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_arb (
        .req   (bus.req),
        .ptr   (ptr_r),
        .gnt   (arb_gnt_s),
        .idx   (arb_idx_s),
        .valid (arb_valid_s)
    );

    assign sel_byte_s = bus.data[int'(arb_idx_s) * 8 +: 8];

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            ptr_r      <= {ID_W{1'b0}};
            shift_r    <= 8'h00;
            par_r      <= 1'b0;
            tick_cnt_r <= 4'd0;
            gnt_r      <= {NUM_REQ{1'b0}};
            baud_en_r  <= 1'b0;
            txd_r      <= 1'b1;
            busy_r     <= 1'b0;
            cur_id_r   <= {ID_W{1'b0}};
        end else begin
            state_r    <= state_s;
            ptr_r      <= ptr_s;
            shift_r    <= shift_s;
            par_r      <= par_s;
            tick_cnt_r <= tick_cnt_s;
            gnt_r      <= gnt_s;
            baud_en_r  <= baud_en_s;
            txd_r      <= txd_s;
            busy_r     <= busy_s;
            cur_id_r   <= cur_id_s;
        end
    end

    // Next-state and next-output logic; tick_cnt counts ticks received this frame.
    always_comb begin
        state_s    = state_r;
        ptr_s      = ptr_r;
        shift_s    = shift_r;
        par_s      = par_r;
        tick_cnt_s = tick_cnt_r;
        gnt_s      = {NUM_REQ{1'b0}};
        baud_en_s  = baud_en_r;
        txd_s      = txd_r;
        busy_s     = busy_r;
        cur_id_s   = cur_id_r;

        case (state_r)
            IDLE: begin
                txd_s     = 1'b1;
                baud_en_s = 1'b0;
                busy_s    = 1'b0;
                if (arb_valid_s) begin
                    shift_s    = sel_byte_s;
                    par_s      = parity_bit(sel_byte_s, PARITY);
                    cur_id_s   = arb_idx_s;
                    ptr_s      = (arb_idx_s == ID_W'(NUM_REQ - 1)) ? {ID_W{1'b0}}
                                                                   : arb_idx_s + ID_W'(1);
                    gnt_s      = arb_gnt_s;
                    busy_s     = 1'b1;
                    baud_en_s  = 1'b1;
                    txd_s      = 1'b0;
                    tick_cnt_s = 4'd0;
                    state_s    = START;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (bus.baud_tick) begin
                    txd_s      = shift_r[0];
                    shift_s    = {1'b0, shift_r[7:1]};
                    tick_cnt_s = 4'd1;
                    state_s    = DATA;
                end else begin
                    state_s = START;
                end
            end
            DATA: begin
                if (bus.baud_tick) begin
                    tick_cnt_s = tick_cnt_r + 4'd1;
                    if (tick_cnt_r == 4'd8) begin
                        if (PARITY != PAR_NONE) begin
                            txd_s   = par_r;
                            state_s = PAR;
                        end else begin
                            txd_s   = 1'b1;
                            state_s = STOP;
                        end
                    end else begin
                        txd_s   = shift_r[0];
                        shift_s = {1'b0, shift_r[7:1]};
                    end
                end else begin
                    state_s = DATA;
                end
            end
            PAR: begin
                if (bus.baud_tick) begin
                    tick_cnt_s = tick_cnt_r + 4'd1;
                    txd_s      = 1'b1;
                    state_s    = STOP;
                end else begin
                    state_s = PAR;
                end
            end
            STOP: begin
                if (bus.baud_tick) begin
                    if (tick_cnt_r == LAST_TICK) begin
                        state_s   = IDLE;
                        busy_s    = 1'b0;
                        baud_en_s = 1'b0;
                        txd_s     = 1'b1;
                    end else begin
                        tick_cnt_s = tick_cnt_r + 4'd1;
                    end
                end else begin
                    state_s = STOP;
                end
            end
            default: begin
                state_s   = IDLE;
                txd_s     = 1'b1;
                busy_s    = 1'b0;
                baud_en_s = 1'b0;
            end
        endcase
    end

    assign bus.gnt     = gnt_r;
    assign bus.baud_en = baud_en_r;
    assign bus.txd     = txd_r;
    assign bus.busy    = busy_r;
    assign bus.cur_id  = cur_id_r;

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Shares one bit-serial UART transmit line between NUM_REQ byte requesters using round-robin arbitration.
- Sequences each frame (start, 8 data bits LSB-first, optional parity, stop bits), timed from an external BaudTickGen tick.
- Gates that tick generator through baud_en. baud_en is high only while a frame is in flight, so every frame's bit timing restarts phase-aligned.
- Sits between the host-side byte producers and the BaudTickGen/txd pin.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, 1 or 2 stop bits.
- ID_W, 2, width of cur_id; must satisfy 2**ID_W >= NUM_REQ.

Ports:
- clk  in  1  system clock, same clock as BaudTickGen.
- rst  in  1  synchronous active-high reset.
- req  in  NUM_REQ  per-requester "byte pending"; level, held until granted.
- data  in  8*NUM_REQ  byte for requester i in data[8*i+7:8*i].
- gnt  out  NUM_REQ  one-cycle one-hot pulse: byte of that requester captured.
- baud_en  out  1  enable to BaudTickGen.
- baud_tick  in  1  one-cycle bit-period tick from BaudTickGen.
- txd  out  1  serial line, idle high.
- busy  out  1  high from grant cycle until frame end.
- cur_id  out  ID_W  index of requester currently being sent; holds last value when idle.

Behaviour:
- Reset values: gnt = 0, baud_en = 0, txd = 1, busy = 0, cur_id = 0, RR pointer = 0 (requester 0 highest priority). Reset mid-frame aborts the frame; txd is 1 on the cycle after rst is sampled.
- States: IDLE, START, DATA, PAR, STOP. All outputs are registered.
- IDLE:
  - txd = 1, baud_en = 0.
  - If req != 0, pick the first asserted requester scanning from ptr upward, wrapping modulo NUM_REQ.
  - Same cycle: latch data byte into the shift register, latch cur_id, set ptr = winner+1 (wrap).
  - Next cycle: gnt[winner] = 1 for exactly one cycle, busy = 1, baud_en = 1, txd = 0, state = START.
- START: hold txd = 0. On baud_tick go to DATA with bitcnt = 0 and txd = shift[0].
- DATA:
  - On baud_tick, shift right; bitcnt increments.
  - After bit 7's tick: go to PAR (PARITY != 0; txd = parity bit) or STOP (txd = 1).
  - Even parity = XOR of the 8 data bits; odd = its inverse.
- PAR: on baud_tick go to STOP, txd = 1.
- STOP:
  - Count STOP_BITS ticks.
  - On the last one: state = IDLE, busy = 0, baud_en = 0, txd stays 1.
- Bit period: BaudTickGen preloads its accumulator while disabled, so the first tick arrives ~one bit time after baud_en rises. Every txd level is held for exactly one tick interval.
- Inter-frame gap: at least 1 clk of idle-high between a stop bit and the next start bit. Back-to-back frames need no other gap.
- baud_tick while IDLE is ignored.
- req is sampled only in IDLE:
  - changes during a frame have no effect;
  - requester data must be stable only in the arbitration cycle;
  - deasserting req before grant withdraws the request without penalty.
- Requester i is granted at most once per NUM_REQ grants while others are pending (fairness).
- Frame length in ticks: 1 + 8 + (PARITY != 0) + STOP_BITS.

Decomposition:
- Shared package uart_pkg: state enum (IDLE/START/DATA/PAR/STOP), PARITY encodings (PAR_NONE/PAR_EVEN/PAR_ODD), frame-length constant function.
- One sub-module, rr_arbiter: combinational round-robin pick from req and ptr. Outputs a one-hot grant plus a valid flag. Reusable for a future RX-side buffer share.
- Framer FSM stays in uart_tx_sched.
- BaudTickGen is instantiated by the parent, not inside this block.

Test Plan:
- Single request, req = 0001, data0 = 8'hA5, PARITY = 0, STOP_BITS = 1, tick model every 16 clk:
  - gnt = 0001 for one cycle; txd = 0,1,0,1,0,0,1,0,1,1 (start, LSB-first A5, stop), each level 16 clk;
  - busy falls after the stop tick; baud_en tracks busy.
- All four requesting continuously, ptr = 0: grant order 0,1,2,3,0,1; cur_id matches each frame; each gnt is a single-cycle pulse.
- PARITY = 1 with byte 8'h07: parity bit = 1. PARITY = 2 with the same byte: parity bit = 0. STOP_BITS = 2: two idle-high tick intervals before busy drops.
- rst asserted during DATA bit 4: next cycle txd = 1, busy = 0, baud_en = 0, gnt = 0. After release with req = 0100, requester 2 is granted (ptr reset to 0 but 2 is the only requester).
- req toggled during a frame and baud_tick pulsed in IDLE: no extra gnt, no txd change. Request dropped before grant: never granted.
- Real BaudTickGen (100 MHz, 9600 baud) in loop: measure start-bit width ≈ 10417 clk ±2%; consecutive frames separated by ≥1 clk of idle high.
